// File: rtl/subtractor_serial.sv
// subtractor_serial: multi-cycle unsigned a - b - borrow, SLICE bits per cycle, LSB slice first
module subtractor_serial #(
  parameter int DATA_SIZE = 16,
  parameter int SLICE = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_in,
  input  logic [DATA_SIZE-1:0] a_in,
  input  logic [DATA_SIZE-1:0] b_in,
  input  logic                 borrow_in,
  output logic                 busy_out,
  output logic                 done_out,
  output logic                 borrow_out,
  output logic [DATA_SIZE-1:0] result_out
);
  localparam int NUM_SLICES = DATA_SIZE / SLICE;
  localparam int CW = NUM_SLICES > 1 ? $clog2(NUM_SLICES) : 1;
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_nx;
  logic [DATA_SIZE-1:0] a_q, b_q, part_q, part_nx;
  logic [SLICE:0] diff;
  logic [CW-1:0] cnt;
  logic borrow_q, last;
  // Operands shift right each cycle so the active slice is always at the bottom;
  // differences enter the partial result from the top and end up in place.
  always_comb begin
    diff = {1'b0, a_q[SLICE-1:0]} - {1'b0, b_q[SLICE-1:0]} - {{SLICE{1'b0}}, borrow_q};
    part_nx = DATA_SIZE'({diff[SLICE-1:0], part_q} >> SLICE);
    last = cnt == CW'(NUM_SLICES - 1);
    state_nx = state == IDLE ? (start_in ? RUN : IDLE) : (last ? IDLE : RUN);
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q <= '0;
      b_q <= '0;
      part_q <= '0;
      borrow_q <= 1'b0;
      cnt <= '0;
      done_out <= 1'b0;
      borrow_out <= 1'b0;
      result_out <= '0;
    end else begin
      done_out <= 1'b0;
      if (state == IDLE && start_in) begin
        a_q <= a_in;
        b_q <= b_in;
        borrow_q <= borrow_in;
        part_q <= '0;
        cnt <= '0;
      end else if (state == RUN) begin
        a_q <= a_q >> SLICE;
        b_q <= b_q >> SLICE;
        part_q <= part_nx;
        borrow_q <= diff[SLICE];
        cnt <= cnt + CW'(1);
        if (last) begin
          result_out <= part_nx;
          borrow_out <= diff[SLICE];
          done_out <= 1'b1;
        end
      end
    end
  end
  assign busy_out = state == RUN;
endmodule

// File: tb/tb_subtractor_serial.sv
// tb_subtractor_serial: randomized and directed checks of subtractor_serial against an arithmetic model
module tb_subtractor_serial;
  localparam int W = 16;
  localparam int N = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic start_in = 1'b0, borrow_in = 1'b0;
  logic [W-1:0] a_in = '0, b_in = '0;
  logic busy_out, done_out, borrow_out;
  logic [W-1:0] result_out;
  logic s_start = 1'b0, s_bin = 1'b0;
  logic [W-1:0] s_a = '0, s_b = '0;
  logic s_busy, s_done, s_bout;
  logic [W-1:0] s_res;
  int n_cmp = 0, n_bad = 0;

  subtractor_serial #(.DATA_SIZE(W), .SLICE(4)) dut (
    .clk(clk), .rst(rst), .start_in(start_in), .a_in(a_in), .b_in(b_in), .borrow_in(borrow_in),
    .busy_out(busy_out), .done_out(done_out), .borrow_out(borrow_out), .result_out(result_out));

  subtractor_serial #(.DATA_SIZE(W), .SLICE(W)) dut16 (
    .clk(clk), .rst(rst), .start_in(s_start), .a_in(s_a), .b_in(s_b), .borrow_in(s_bin),
    .busy_out(s_busy), .done_out(s_done), .borrow_out(s_bout), .result_out(s_res));

  always #5 clk = ~clk;

  function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic bin);
    logic [W:0] full_b;
    full_b = {1'b0, b} + {{W{1'b0}}, bin};
    return {{1'b0, a} < full_b, W'(a - b - {{(W-1){1'b0}}, bin})};
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({busy_out, done_out, borrow_out, result_out} !== '0) begin
      n_bad++;
      $display("FAIL reset4: got busy=%b done=%b bout=%b res=%h want all 0", busy_out, done_out, borrow_out, result_out);
    end
    n_cmp++;
    if ({s_busy, s_done, s_bout, s_res} !== '0) begin
      n_bad++;
      $display("FAIL reset16: got busy=%b done=%b bout=%b res=%h want all 0", s_busy, s_done, s_bout, s_res);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic do_op(input logic [W-1:0] a, b, input logic bin, input string tag);
    logic [W:0] exp;
    int lat;
    exp = model(a, b, bin);
    @(negedge clk);
    a_in = a; b_in = b; borrow_in = bin; start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0; a_in = W'($urandom); b_in = W'($urandom); borrow_in = 1'($urandom);
    lat = 0;
    while (!done_out && lat < 3 * N) begin
      n_cmp++;
      if (busy_out !== 1'b1) begin
        n_bad++;
        $display("FAIL %s busy: got %b want 1 at cycle %0d", tag, busy_out, lat);
      end
      @(posedge clk);
      #1;
      lat++;
    end
    n_cmp++;
    if (lat !== N) begin
      n_bad++;
      $display("FAIL %s latency: got %0d want %0d", tag, lat, N);
    end
    n_cmp++;
    if ({borrow_out, result_out} !== exp) begin
      n_bad++;
      $display("FAIL %s value: got bout=%b res=%h want bout=%b res=%h", tag, borrow_out, result_out, exp[W], exp[W-1:0]);
    end
    n_cmp++;
    if (busy_out !== 1'b0) begin
      n_bad++;
      $display("FAIL %s busy_at_done: got %b want 0", tag, busy_out);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done_out !== 1'b0 || {borrow_out, result_out} !== exp) begin
      n_bad++;
      $display("FAIL %s hold: got done=%b bout=%b res=%h want done=0 bout=%b res=%h", tag, done_out, borrow_out, result_out, exp[W], exp[W-1:0]);
    end
  endtask

  task automatic test_directed;
    do_op(16'h1234, 16'h0034, 1'b0, "case1");
    do_op(16'h0000, 16'h0001, 1'b0, "case2_wrap");
    do_op(16'h8000, 16'h7FFF, 1'b1, "case3_ripple");
    do_op(16'hFFFF, 16'hFFFF, 1'b1, "all_ones_bin");
  endtask

  task automatic test_random;
    for (int i = 0; i < 20; i++)
      do_op(W'($urandom), W'($urandom), 1'($urandom), $sformatf("rand%0d", i));
  endtask

  task automatic test_ignore_start;
    int dones;
    dones = 0;
    @(negedge clk);
    a_in = 16'd5; b_in = 16'd3; borrow_in = 1'b0; start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (done_out !== (k == N)) begin
        n_bad++;
        $display("FAIL ignore_start done k=%0d: got %b want %b", k, done_out, k == N);
      end
      if (done_out) dones++;
      if (k == 1) begin start_in = 1'b1; a_in = 16'd0; b_in = 16'd1; end
      if (k == 2) start_in = 1'b0;
    end
    n_cmp++;
    if (dones !== 1 || {borrow_out, result_out} !== 17'h00002) begin
      n_bad++;
      $display("FAIL ignore_start result: got dones=%0d bout=%b res=%h want 1 0 0002", dones, borrow_out, result_out);
    end
  endtask

  task automatic test_reset_abort;
    @(negedge clk);
    a_in = 16'h00FF; b_in = 16'h0F00; borrow_in = 1'b1; start_in = 1'b1;
    @(posedge clk);
    #1;
    start_in = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (done_out !== 1'b0) begin
        n_bad++;
        $display("FAIL abort done k=%0d: got %b want 0", k, done_out);
      end
      if (k >= 3) begin
        n_cmp++;
        if ({busy_out, borrow_out, result_out} !== '0) begin
          n_bad++;
          $display("FAIL abort clear k=%0d: got busy=%b bout=%b res=%h want 0", k, busy_out, borrow_out, result_out);
        end
      end
      if (k == 2) rst = 1'b1;
      if (k == 3) rst = 1'b0;
    end
    do_op(16'd9, 16'd9, 1'b0, "after_abort");
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a1, b1, a2, b2;
    logic c1, c2;
    logic [W:0] e1, e2;
    a1 = W'($urandom); b1 = W'($urandom); c1 = 1'($urandom);
    a2 = 16'h0000; b2 = 16'h0001; c2 = 1'b0;
    e1 = model(a1, b1, c1);
    e2 = model(a2, b2, c2);
    @(negedge clk);
    a_in = a1; b_in = b1; borrow_in = c1; start_in = 1'b1;
    @(posedge clk);
    #1;
    for (int k = 1; k <= 14; k++) begin
      @(posedge clk);
      #1;
      n_cmp++;
      if (done_out !== (k == N || k == 2 * N + 1)) begin
        n_bad++;
        $display("FAIL b2b done k=%0d: got %b want %b", k, done_out, k == N || k == 2 * N + 1);
      end
      if (k == N) begin
        n_cmp++;
        if ({borrow_out, result_out} !== e1) begin
          n_bad++;
          $display("FAIL b2b op1: got %h want %h", {borrow_out, result_out}, e1);
        end
      end
      if (k == 2 * N + 1) begin
        n_cmp++;
        if ({borrow_out, result_out} !== e2) begin
          n_bad++;
          $display("FAIL b2b op2: got %h want %h", {borrow_out, result_out}, e2);
        end
        start_in = 1'b0;
      end
      if (k == 1) begin a_in = a2; b_in = b2; borrow_in = c2; end
    end
  endtask

  task automatic test_single_slice;
    for (int i = 0; i < 6; i++) begin
      logic [W-1:0] a, b;
      logic c;
      logic [W:0] exp;
      a = (i == 0) ? 16'h0000 : W'($urandom);
      b = (i == 0) ? 16'h0001 : W'($urandom);
      c = (i == 0) ? 1'b0 : 1'($urandom);
      exp = model(a, b, c);
      @(negedge clk);
      s_a = a; s_b = b; s_bin = c; s_start = 1'b1;
      @(posedge clk);
      #1;
      s_start = 1'b0; s_a = W'($urandom); s_b = W'($urandom);
      n_cmp++;
      if (s_busy !== 1'b1 || s_done !== 1'b0) begin
        n_bad++;
        $display("FAIL slice16_run%0d: got busy=%b done=%b want 1 0", i, s_busy, s_done);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (s_done !== 1'b1 || s_busy !== 1'b0 || {s_bout, s_res} !== exp) begin
        n_bad++;
        $display("FAIL slice16_done%0d: got done=%b busy=%b bout=%b res=%h want 1 0 %b %h", i, s_done, s_busy, s_bout, s_res, exp[W], exp[W-1:0]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_random;
    test_ignore_start;
    test_reset_abort;
    test_back_to_back;
    test_single_slice;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
